// File: rtl/program_loader.sv
// program_loader
// Host-side writer for the fetch-stage instruction-memory load port. Accepts
// a stream of instruction words over a valid/ready handshake. It writes each
// word into instruction memory through a registered write port. It holds the
// processor in reset until the whole program is written, then releases it
// after a fixed hold interval.
//
// Ports:
//   clk             in  : single clock, rising edge
//   reset           in  : asynchronous, active-high
//   load_start      in  : begin a new load session (pulse)
//   load_valid      in  : host word valid
//   load_data       in  : instruction word
//   load_last       in  : marks the final word of the program
//   load_ready      out : loader accepts a word this cycle
//   write_enable_fm out : instruction-memory write strobe
//   write_addr_fm   out : instruction-memory write address
//   write_data_fm   out : instruction-memory write data
//   rst_fm          out : fetch-module reset pulse (one cycle, in CLEAR)
//   cpu_reset       out : processor reset hold
//   done            out : program loaded, processor running
//   error           out : program exceeded MEM_DEPTH words
//   word_count      out : words accepted this session
module program_loader #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int START_ADDR  = 0,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       write_enable_fm,
  output logic [ADDR_W-1:0]          write_addr_fm,
  output logic [DATA_W-1:0]          write_data_fm,
  output logic                       rst_fm,
  output logic                       cpu_reset,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(MEM_DEPTH):0] word_count
);

  localparam int WC_W   = $clog2(MEM_DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    ERROR   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WC_W-1:0]     count_q, count_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rst_fm_q, rst_fm_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                accept_s;

  // The registered ready is what the host sees, so a beat is taken exactly
  // when the host sees ready high together with its own valid.
  assign accept_s = load_valid & ready_q;

  // Next-state, counter and write-port logic; all outputs are registered and
  // derived from the next state so they change on the same edge as the FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE, RUN, ERROR: begin
        if (load_start) begin
          state_d = CLEAR;
          // Counters are cleared on entry so word_count already reads 0 in CLEAR.
          addr_d  = ADDR_W'(START_ADDR);
          count_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      CLEAR: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (accept_s) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = load_data;
          addr_d  = addr_q + ADDR_W'(1);
          if (count_q != WC_W'(MEM_DEPTH)) begin
            count_d = count_q + WC_W'(1);
          end else begin
            count_d = count_q;
          end
          // A last word that exactly fills memory is a legal full program;
          // filling memory without last means the program cannot fit.
          if (load_last) begin
            state_d = RELEASE;
            hold_d  = HOLD_W'(HOLD_CYCLES);
          end else if (count_q == WC_W'(MEM_DEPTH - 1)) begin
            state_d = ERROR;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      RELEASE: begin
        if (hold_q == '0) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d     = (state_d == LOAD);
    rst_fm_d    = (state_d == CLEAR);
    cpu_reset_d = (state_d != RUN);
    done_d      = (state_d == RUN);
    error_d     = (state_d == ERROR);
  end

  // State, counters and registered outputs; reset holds the processor in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rst_fm_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      rst_fm_q    <= rst_fm_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign load_ready      = ready_q;
  assign write_enable_fm = we_q;
  assign write_addr_fm   = waddr_q;
  assign write_data_fm   = wdata_q;
  assign rst_fm          = rst_fm_q;
  assign cpu_reset       = cpu_reset_q;
  assign done            = done_q;
  assign error           = error_q;
  assign word_count      = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader, built with MEM_DEPTH=4, START_ADDR=0x10
// and HOLD_CYCLES=4, so a single instance covers the offset address, overflow
// and full-program cases.
module tb_program_loader;

  localparam int SA = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        load_last = 1'b0;
  logic        load_ready, write_enable_fm, rst_fm, cpu_reset, done, error;
  logic [31:0] write_addr_fm;
  logic [15:0] write_data_fm;
  logic [2:0]  word_count;

  int total = 0;
  int bad = 0;

  logic [31:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [15:0] w [3] = '{16'h1111, 16'h2222, 16'h3333};

  program_loader #(
    .DATA_W(16), .ADDR_W(32), .MEM_DEPTH(4), .START_ADDR(SA), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .write_enable_fm(write_enable_fm), .write_addr_fm(write_addr_fm),
    .write_data_fm(write_data_fm), .rst_fm(rst_fm), .cpu_reset(cpu_reset),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Log every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_enable_fm === 1'b1) begin
      wa_q.push_back(write_addr_fm);
      wd_q.push_back(write_data_fm);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic flush;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_reset;
    tick; tick;
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset got=%0h exp=1", cpu_reset); end
    total++; if (rst_fm !== 1'b0) begin bad++; $display("FAIL rst_rst_fm got=%0h exp=0", rst_fm); end
    total++; if (write_enable_fm !== 1'b0) begin bad++; $display("FAIL rst_we got=%0h exp=0", write_enable_fm); end
    total++; if (write_addr_fm !== 32'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", write_addr_fm); end
    total++; if (write_data_fm !== 16'h0) begin bad++; $display("FAIL rst_data got=%0h exp=0", write_data_fm); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", load_ready); end
    total++; if ({done, error} !== 2'b00) begin bad++; $display("FAIL rst_done_err got=%0h exp=0", {done, error}); end
    total++; if (word_count !== 3'd0) begin bad++; $display("FAIL rst_wc got=%0h exp=0", word_count); end
    reset = 1'b0;
    // Valid without a session must be ignored while idle.
    load_valid = 1'b1; load_data = 16'habcd;
    tick; tick; tick;
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%0h exp=0", load_ready); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL idle_cpu_reset got=%0h exp=1", cpu_reset); end
    total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL idle_writes got=%0d exp=0", wa_q.size()); end
    load_valid = 1'b0;
  endtask

  task automatic test_basic;
    flush();
    load_start = 1'b1; tick; load_start = 1'b0;
    total++; if (rst_fm !== 1'b1) begin bad++; $display("FAIL clr_rst_fm got=%0h exp=1", rst_fm); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%0h exp=0", load_ready); end
    total++; if (word_count !== 3'd0) begin bad++; $display("FAIL clr_wc got=%0h exp=0", word_count); end
    tick;
    total++; if (rst_fm !== 1'b0) begin bad++; $display("FAIL load_rst_fm got=%0h exp=0", rst_fm); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%0h exp=1", load_ready); end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = w[i]; load_last = (i == 2);
      tick;
      total++; if (write_enable_fm !== 1'b1) begin bad++; $display("FAIL b2b_we[%0d] got=%0h exp=1", i, write_enable_fm); end
      total++; if (write_addr_fm !== 32'(SA + i)) begin bad++; $display("FAIL b2b_addr[%0d] got=%0h exp=%0h", i, write_addr_fm, SA + i); end
      total++; if (write_data_fm !== w[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, write_data_fm, w[i]); end
    end
    load_valid = 1'b0; load_last = 1'b0;
    total++; if (word_count !== 3'd3) begin bad++; $display("FAIL b2b_wc got=%0h exp=3", word_count); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rel_ready got=%0h exp=0", load_ready); end
    // Last accept was edge N; the processor must stay in reset through edge N+4.
    for (int k = 1; k <= 4; k++) begin
      tick;
      total++; if ({cpu_reset, done, write_enable_fm} !== 3'b100) begin bad++; $display("FAIL hold[%0d] got=%0b exp=100", k, {cpu_reset, done, write_enable_fm}); end
    end
    tick;
    total++; if ({cpu_reset, done} !== 2'b01) begin bad++; $display("FAIL run got=%0b exp=01", {cpu_reset, done}); end
    total++; if (wa_q.size() !== 3) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=3", wa_q.size()); end
  endtask

  task automatic test_gapped;
    int n;
    flush();
    load_start = 1'b1; tick; load_start = 1'b0;
    total++; if ({rst_fm, cpu_reset, done} !== 3'b110) begin bad++; $display("FAIL reload_clr got=%0b exp=110", {rst_fm, cpu_reset, done}); end
    tick;
    for (int i = 0; i < 6; i++) begin
      load_valid = (i % 2 == 0);
      load_data = (i % 2 == 0) ? w[i / 2] : 16'hdead;
      load_last = (i == 4);
      tick;
      total++; if (write_enable_fm !== (i % 2 == 0)) begin bad++; $display("FAIL gap_we[%0d] got=%0h exp=%0h", i, write_enable_fm, (i % 2 == 0)); end
    end
    load_valid = 1'b0; load_last = 1'b0;
    total++; if (wa_q.size() !== 3) begin bad++; $display("FAIL gap_nwrites got=%0d exp=3", wa_q.size()); end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      total++; if (wa_q[i] !== 32'(SA + i) || wd_q[i] !== w[i]) begin bad++; $display("FAIL gap_write[%0d] got=%0h/%0h exp=%0h/%0h", i, wa_q[i], wd_q[i], SA + i, w[i]); end
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick; n++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL gap_done got=%0h exp=1", done); end
  endtask

  task automatic test_overflow;
    flush();
    load_start = 1'b1; tick; load_start = 1'b0; tick;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = 16'h4000 + 16'(i); load_last = (i == 4);
      tick;
      if (i == 3) begin
        total++; if ({error, load_ready, cpu_reset} !== 3'b101) begin bad++; $display("FAIL ovf_flags got=%0b exp=101", {error, load_ready, cpu_reset}); end
        total++; if (word_count !== 3'd4) begin bad++; $display("FAIL ovf_wc got=%0h exp=4", word_count); end
        total++; if (write_enable_fm !== 1'b1 || write_addr_fm !== 32'(SA + 3)) begin bad++; $display("FAIL ovf_4th got=%0h/%0h exp=1/%0h", write_enable_fm, write_addr_fm, SA + 3); end
      end
      if (i == 4) begin
        total++; if (write_enable_fm !== 1'b0) begin bad++; $display("FAIL ovf_5th_we got=%0h exp=0", write_enable_fm); end
      end
    end
    load_valid = 1'b0; load_last = 1'b0;
    tick; tick;
    total++; if (wa_q.size() !== 4) begin bad++; $display("FAIL ovf_nwrites got=%0d exp=4", wa_q.size()); end
    total++; if (wa_q.size() == 4 && (wa_q[3] !== 32'(SA + 3) || wd_q[3] !== 16'h4003)) begin bad++; $display("FAIL ovf_last_write got=%0h/%0h exp=%0h/4003", wa_q[3], wd_q[3], SA + 3); end
    total++; if ({error, cpu_reset, done} !== 3'b110) begin bad++; $display("FAIL ovf_stay got=%0b exp=110", {error, cpu_reset, done}); end
    load_start = 1'b1; tick; load_start = 1'b0;
    total++; if ({error, rst_fm} !== 2'b01) begin bad++; $display("FAIL ovf_reload got=%0b exp=01", {error, rst_fm}); end
  endtask

  task automatic test_full;
    int n;
    flush();
    tick;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 16'h5000 + 16'(i); load_last = (i == 3);
      tick;
    end
    load_valid = 1'b0; load_last = 1'b0;
    total++; if ({error, load_ready} !== 2'b00) begin bad++; $display("FAIL full_flags got=%0b exp=00", {error, load_ready}); end
    total++; if (word_count !== 3'd4) begin bad++; $display("FAIL full_wc got=%0h exp=4", word_count); end
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick; n++; end
    total++; if ({done, error, cpu_reset} !== 3'b100) begin bad++; $display("FAIL full_run got=%0b exp=100", {done, error, cpu_reset}); end
    total++; if (wa_q.size() !== 4) begin bad++; $display("FAIL full_nwrites got=%0d exp=4", wa_q.size()); end
  endtask

  task automatic test_async_reset;
    flush();
    load_start = 1'b1; tick; load_start = 1'b0; tick;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 16'h6000 + 16'(i); load_last = 1'b0;
      tick;
    end
    load_data = 16'h6002;
    #2; reset = 1'b1; #1;
    total++; if ({write_enable_fm, load_ready, rst_fm, done, error} !== 5'b0) begin bad++; $display("FAIL ar_ctrl got=%0b exp=00000", {write_enable_fm, load_ready, rst_fm, done, error}); end
    total++; if (write_addr_fm !== 32'h0 || write_data_fm !== 16'h0) begin bad++; $display("FAIL ar_port got=%0h/%0h exp=0/0", write_addr_fm, write_data_fm); end
    total++; if (cpu_reset !== 1'b1 || word_count !== 3'd0) begin bad++; $display("FAIL ar_cpu_wc got=%0h/%0h exp=1/0", cpu_reset, word_count); end
    flush();
    tick; reset = 1'b0;
    tick; tick; tick;
    load_valid = 1'b0;
    total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL ar_writes got=%0d exp=0", wa_q.size()); end
    total++; if ({load_ready, cpu_reset} !== 2'b01) begin bad++; $display("FAIL ar_idle got=%0b exp=01", {load_ready, cpu_reset}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overflow();
    test_full();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side writer for the instruction-memory load port of the fetch stage. It accepts a stream of 16-bit instruction words over a valid/ready handshake and drives `write_enable_fm`, `write_addr_fm`, `write_data_fm` and `rst_fm` of the fetch module. It holds the processor in reset (`cpu_reset`) until the program is fully written, then releases it after a fixed hold interval. It sits between the test/host interface and the top-level `pipelinedProcessor` inputs.

## Interface
- `DATA_W`, 16, instruction word width
- `ADDR_W`, 32, width of `write_addr_fm`
- `MEM_DEPTH`, 1024, maximum number of words in instruction memory
- `START_ADDR`, 0, word address of the first loaded instruction
- `HOLD_CYCLES`, 4, cycles `cpu_reset` stays high after the last write (≥1)

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-high
- `load_start` in 1: begin a new load session (pulse)
- `load_valid` in 1: host word valid
- `load_data` in DATA_W: instruction word
- `load_last` in 1: qualifies final word of program
- `load_ready` out 1: loader accepts a word this cycle
- `write_enable_fm` out 1: instruction-memory write strobe
- `write_addr_fm` out ADDR_W: instruction-memory write address
- `write_data_fm` out DATA_W: instruction-memory write data
- `rst_fm` out 1: fetch-module reset pulse
- `cpu_reset` out 1: processor reset hold
- `done` out 1: program loaded, processor running
- `error` out 1: overflow; program exceeded MEM_DEPTH
- `word_count` out clog2(MEM_DEPTH)+1: words accepted this session

## Operation
- States: IDLE, CLEAR, LOAD, RELEASE, RUN, ERROR.
- IDLE: `cpu_reset`=1, `load_ready`=0. `load_start` → CLEAR.
- CLEAR (one cycle): `rst_fm`=1, `cpu_reset`=1, address counter ← START_ADDR, `word_count` ← 0, `done` ← 0, `error` ← 0. → LOAD.
- LOAD: `load_ready`=1. Beat accepted when `load_valid && load_ready`; `word_count` increments, address counter increments by 1. `load_start` ignored in LOAD.
  - Accepted beat with `load_last`=1 → RELEASE (counter loaded with HOLD_CYCLES).
  - Accepted beat without `load_last` that makes `word_count`==MEM_DEPTH → ERROR.
  - Accepted beat with `load_last` and `word_count` reaching exactly MEM_DEPTH → RELEASE (legal full program).
- RELEASE: `load_ready`=0, `cpu_reset`=1; decrement hold counter; at 0 → RUN.
- RUN: `cpu_reset`=0, `done`=1. `load_start` → CLEAR (reload; `cpu_reset` reasserts in CLEAR).
- ERROR: `error`=1, `cpu_reset`=1, `load_ready`=0. Only `load_start` (→ CLEAR) or `reset` exits.
- `load_valid` outside LOAD has no effect; no word is written.
- `word_count` saturates at MEM_DEPTH; address counter never written beyond START_ADDR+MEM_DEPTH-1.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, `rst_fm`=0, `write_enable_fm`=0, `write_addr_fm`=0, `write_data_fm`=0, `load_ready`=0, `done`=0, `error`=0, `word_count`=0.
- Write port registered: beat accepted at edge N → `write_enable_fm`=1 with that beat's address/data during cycle N+1, memory commits at edge N+1. `write_enable_fm` is a single-cycle pulse per beat; back-to-back beats give continuous strobe, one word per cycle.
- Final word's strobe occurs in the first RELEASE (or ERROR) cycle; the overflow word is still written.
- `load_start` at edge N → CLEAR during N+1 (`rst_fm` high one cycle) → `load_ready`=1 from N+2.
- Last beat accepted at edge N → `cpu_reset` falls and `done` rises at edge N+HOLD_CYCLES+1.
- `reset` mid-session: immediate asynchronous return to reset values; partial program left in memory, no further writes.

## Test plan
- Reset → all outputs at reset values; `cpu_reset`=1, state IDLE until `load_start`.
- `load_start`, then 3 back-to-back beats 0x1111, 0x2222, 0x3333 (last on third) → `rst_fm` one-cycle pulse; writes at addresses 0,1,2 on three consecutive cycles; `word_count`=3; `cpu_reset` low and `done`=1 exactly 5 cycles after last accept (HOLD_CYCLES=4).
- Same load with `load_valid` toggling every other cycle and START_ADDR=0x10 → writes only on accepted beats, addresses 0x10–0x12, no strobe on idle cycles.
- MEM_DEPTH=4, send 5 words with `load_last` on the fifth → after 4th accept `error`=1, `load_ready`=0, 4 writes only (addr 0–3), `cpu_reset` stays 1; `load_start` clears `error` and reloads.
- MEM_DEPTH=4, exactly 4 words with `load_last` on fourth → no error, `done`=1.
- Assert `reset` asynchronously after 2 of 5 beats → outputs return to reset values before next edge; `load_start` while in RUN → `cpu_reset` reasserts and `done` clears in CLEAR cycle.
